// File: rtl/relu_quant_pkg.sv
// Shared defaults and sum-width helper for the ReLU/quantise pipeline.
package relu_quant_pkg;

  localparam int unsigned DEF_CH     = 3;
  localparam int unsigned DEF_IN_W   = 29;
  localparam int unsigned DEF_BIAS_W = 16;
  localparam int unsigned DEF_OUT_W  = 8;
  localparam int unsigned DEF_SHIFT  = 6;

  // Wide enough that CH channels plus bias can never overflow.
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned bias_w,
                                            input int unsigned ch);
    int unsigned w;
    w = (in_w > bias_w) ? in_w : bias_w;
    return w + unsigned'($clog2(ch + 1));
  endfunction

endpackage

// File: rtl/relu_quant_core.sv
// Combinational sign-extending adder over CH packed partial sums plus a bias.
module relu_quant_core
  import relu_quant_pkg::*;
#(
  parameter int unsigned CH     = DEF_CH,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned BIAS_W = DEF_BIAS_W,
  parameter int unsigned SUM_W  = sum_width(DEF_IN_W, DEF_BIAS_W, DEF_CH)
) (
  input  logic [CH*IN_W-1:0] data,
  input  logic [BIAS_W-1:0]  bias,
  output logic [SUM_W-1:0]   sum
);

  logic [IN_W-1:0] chan;

  // Two's complement add on explicitly sign-extended operands.
  always_comb begin
    chan = '0;
    sum  = {{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias};
    for (int c = 0; c < int'(CH); c++) begin
      chan = data[c*IN_W +: IN_W];
      sum  = sum + {{(SUM_W - IN_W){chan[IN_W-1]}}, chan};
    end
  end

endmodule

// File: rtl/relu_quant_pipe.sv
// Two-stage sum + ReLU/shift quantiser with zero/clip statistics.
// Define RELU_QUANT_SAT_EN to saturate overflowing outputs instead of truncating.
module relu_quant_pipe
  import relu_quant_pkg::*;
#(
  parameter int unsigned CH     = DEF_CH,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned BIAS_W = DEF_BIAS_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SHIFT  = DEF_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*IN_W-1:0]   in_data,
  input  logic [BIAS_W-1:0]    in_bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  input  logic                 stat_clr,
  output logic [15:0]          zero_cnt,
  output logic [15:0]          clip_cnt
);

  localparam int unsigned SUM_W = sum_width(IN_W, BIAS_W, CH);

  logic             advance;
  logic             load2;
  logic             s1_valid_q;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic [SUM_W-1:0] shifted;
  logic             is_pos, is_clip;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic [15:0]      zero_cnt_d, zero_cnt_q;
  logic [15:0]      clip_cnt_d, clip_cnt_q;

  assign advance   = !out_valid_q || out_ready;
  assign load2     = advance && s1_valid_q;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign zero_cnt  = zero_cnt_q;
  assign clip_cnt  = clip_cnt_q;

  relu_quant_core #(
    .CH     (CH),
    .IN_W   (IN_W),
    .BIAS_W (BIAS_W),
    .SUM_W  (SUM_W)
  ) u_core (
    .data (in_data),
    .bias (in_bias),
    .sum  (sum_d)
  );

  always_comb begin
    is_pos     = !sum_q[SUM_W-1] && (|sum_q);
    shifted    = sum_q >> SHIFT;
    is_clip    = is_pos && (|shifted[SUM_W-1:OUT_W]);
    out_data_d = '0;
    if (is_pos) begin
`ifdef RELU_QUANT_SAT_EN
      out_data_d = is_clip ? '1 : shifted[OUT_W-1:0];
`else
      out_data_d = shifted[OUT_W-1:0];
`endif
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    clip_cnt_d = clip_cnt_q;
    if (stat_clr) begin
      zero_cnt_d = '0;
      clip_cnt_d = '0;
    end else if (load2) begin
      if (!is_pos && zero_cnt_q != 16'hFFFF) zero_cnt_d = zero_cnt_q + 16'd1;
      if (is_clip && clip_cnt_q != 16'hFFFF) clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      zero_cnt_q  <= '0;
      clip_cnt_q  <= '0;
    end else begin
      if (advance) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (in_valid)   sum_q      <= sum_d;
        if (s1_valid_q) out_data_q <= out_data_d;
      end
      zero_cnt_q <= zero_cnt_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

endmodule
